// File: rtl/vga_pkg.sv
// Shared timing constants and counter types for the video pipeline.
// Defaults describe 800x600 with a 1056x628 total raster.
package vga_pkg;

  localparam int CNT_W = 11;

  localparam int HOR_PIXELS      = 800;
  localparam int HOR_FRONT_PORCH = 40;
  localparam int HOR_SYNC        = 128;
  localparam int HOR_BACK_PORCH  = 88;
  localparam int HOR_TOTAL       = HOR_PIXELS + HOR_FRONT_PORCH
                                 + HOR_SYNC + HOR_BACK_PORCH;
  localparam int HOR_SYNC_START  = HOR_PIXELS + HOR_FRONT_PORCH;
  localparam int HOR_SYNC_END    = HOR_SYNC_START + HOR_SYNC;

  localparam int VER_PIXELS      = 600;
  localparam int VER_FRONT_PORCH = 1;
  localparam int VER_SYNC        = 4;
  localparam int VER_BACK_PORCH  = 23;
  localparam int VER_TOTAL       = VER_PIXELS + VER_FRONT_PORCH
                                 + VER_SYNC + VER_BACK_PORCH;
  localparam int VER_SYNC_START  = VER_PIXELS + VER_FRONT_PORCH;
  localparam int VER_SYNC_END    = VER_SYNC_START + VER_SYNC;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/vga_if.sv
// Timing stream between video pipeline stages: raster counts,
// sync/blank strobes and pixel colour.
interface vga_if;
  import vga_pkg::*;

  cnt_t        vcount;
  logic        vsync;
  logic        vblnk;
  cnt_t        hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport master (
    output vcount, vsync, vblnk,
    output hcount, hsync, hblnk, rgb
  );

  modport slave (
    input vcount, vsync, vblnk,
    input hcount, hsync, hblnk, rgb
  );

endinterface

// File: rtl/vga_axis_counter.sv
// Modulo-TOTAL counter with enable; blank/sync decoded from the next count
// and registered so they line up with count. Ports: clk, rst, en, count,
// last (count at TOTAL-1), blnk, sync.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int   TOTAL      = HOR_TOTAL,
  parameter int   BLNK_START = HOR_PIXELS,
  parameter int   SYNC_START = HOR_SYNC_START,
  parameter int   SYNC_END   = HOR_SYNC_END,
  parameter logic SYNC_POL   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output cnt_t count,
  output logic last,
  output logic blnk,
  output logic sync
);

  localparam int XW = CNT_W + 1;

  cnt_t          nxt;
  logic [XW-1:0] nxt_x;
  logic          nxt_in_sync;

  assign last  = (count == cnt_t'(TOTAL - 1));
  assign nxt   = last ? '0 : count + cnt_t'(1);
  // one extra bit so an end bound of 2048 still compares correctly
  assign nxt_x = {1'b0, nxt};

  assign nxt_in_sync = (nxt_x >= XW'(SYNC_START))
                    && (nxt_x <  XW'(SYNC_END));

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      blnk  <= 1'b0;
      sync  <= ~SYNC_POL;
    end else if (en) begin
      count <= nxt;
      blnk  <= (nxt_x >= XW'(BLNK_START));
      sync  <= nxt_in_sync ? SYNC_POL : ~SYNC_POL;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: drives hcount/vcount, sync/blank strobes and a
// zero rgb onto the out stream, plus frame_start at pixel (0,0).
module vga_timing_gen #(
  parameter int   HOR_PIXELS      = vga_pkg::HOR_PIXELS,
  parameter int   HOR_FRONT_PORCH = vga_pkg::HOR_FRONT_PORCH,
  parameter int   HOR_SYNC        = vga_pkg::HOR_SYNC,
  parameter int   HOR_BACK_PORCH  = vga_pkg::HOR_BACK_PORCH,
  parameter int   VER_PIXELS      = vga_pkg::VER_PIXELS,
  parameter int   VER_FRONT_PORCH = vga_pkg::VER_FRONT_PORCH,
  parameter int   VER_SYNC        = vga_pkg::VER_SYNC,
  parameter int   VER_BACK_PORCH  = vga_pkg::VER_BACK_PORCH,
  parameter logic SYNC_POL        = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     en,
  vga_if.master    out,
  output logic     frame_start
);
  import vga_pkg::*;

  localparam int H_TOTAL = HOR_PIXELS + HOR_FRONT_PORCH
                         + HOR_SYNC + HOR_BACK_PORCH;
  localparam int V_TOTAL = VER_PIXELS + VER_FRONT_PORCH
                         + VER_SYNC + VER_BACK_PORCH;
  localparam int H_SS = HOR_PIXELS + HOR_FRONT_PORCH;
  localparam int H_SE = H_SS + HOR_SYNC;
  localparam int V_SS = VER_PIXELS + VER_FRONT_PORCH;
  localparam int V_SE = V_SS + VER_SYNC;

  if (H_TOTAL > 2048 || V_TOTAL > 2048) begin : g_range_chk
    $error("vga_timing_gen: raster total exceeds 11-bit counters");
  end

  logic h_last;
  logic v_last;
  logic v_en;

  // vertical steps only on the edge where the line wraps
  assign v_en = en & h_last;

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .BLNK_START (HOR_PIXELS),
    .SYNC_START (H_SS),
    .SYNC_END   (H_SE),
    .SYNC_POL   (SYNC_POL)
  ) u_hor (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .count (out.hcount),
    .last  (h_last),
    .blnk  (out.hblnk),
    .sync  (out.hsync)
  );

  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .BLNK_START (VER_PIXELS),
    .SYNC_START (V_SS),
    .SYNC_END   (V_SE),
    .SYNC_POL   (SYNC_POL)
  ) u_ver (
    .clk   (clk),
    .rst   (rst),
    .en    (v_en),
    .count (out.vcount),
    .last  (v_last),
    .blnk  (out.vblnk),
    .sync  (out.vsync)
  );

  // next position is (0,0) exactly when both axes sit at their last value
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_start <= 1'b0;
    end else if (en) begin
      frame_start <= h_last & v_last;
    end
  end

  always_ff @(posedge clk) begin
    out.rgb <= '0;
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: default raster for horizontal timing, a tiny raster
// (15x8) for vertical/frame behaviour, and an inverted-polarity copy.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  logic fs_a, fs_b, fs_c;

  always #5 clk = ~clk;

  vga_if ia ();
  vga_if ib ();
  vga_if ic ();

  vga_timing_gen dut_a (
    .clk(clk), .rst(rst), .en(en),
    .out(ia.master), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .HOR_PIXELS(8), .HOR_FRONT_PORCH(2),
    .HOR_SYNC(3), .HOR_BACK_PORCH(2),
    .VER_PIXELS(4), .VER_FRONT_PORCH(1),
    .VER_SYNC(2), .VER_BACK_PORCH(1),
    .SYNC_POL(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en),
    .out(ib.master), .frame_start(fs_b)
  );

  vga_timing_gen #(
    .HOR_PIXELS(8), .HOR_FRONT_PORCH(2),
    .HOR_SYNC(3), .HOR_BACK_PORCH(2),
    .VER_PIXELS(4), .VER_FRONT_PORCH(1),
    .VER_SYNC(2), .VER_BACK_PORCH(1),
    .SYNC_POL(1'b0)
  ) dut_c (
    .clk(clk), .rst(rst), .en(en),
    .out(ic.master), .frame_start(fs_c)
  );

  typedef struct {
    int ah; int av; bit afs;
    int bh; int bv; bit bfs;
    int ph;
  } exp_t;

  exp_t q[$];
  int   ncmp = 0;
  int   nbad = 0;

  int mah = 0, mav = 0, mbh = 0, mbv = 0;
  bit mafs = 0, mbfs = 0;
  int phase = 1;

  // expected output word from a position and hand-derived ranges
  function automatic logic [38:0] pk(
    input int h, input int v, input bit fs,
    input int hp, input int hss, input int hse,
    input int vp, input int vss, input int vse,
    input bit pol
  );
    logic hs, hb, vs, vb;
    hb = (h >= hp);
    vb = (v >= vp);
    hs = (h >= hss && h < hse) ? pol : !pol;
    vs = (v >= vss && v < vse) ? pol : !pol;
    return {11'(v), 11'(h), vs, vb, hs, hb, fs, 12'h000};
  endfunction

  function automatic logic [38:0] act(
    input logic [10:0] v, input logic [10:0] h,
    input logic vs, input logic vb,
    input logic hs, input logic hb,
    input logic fs, input logic [11:0] rgb
  );
    return {v, h, vs, vb, hs, hb, fs, rgb};
  endfunction

  task automatic chk(input string nm,
                     input logic [38:0] a,
                     input logic [38:0] e);
    ncmp++;
    if (a !== e) begin
      nbad++;
      $display("FAIL %s: got v=%0d h=%0d flags=%b want v=%0d h=%0d flags=%b",
               nm, a[38:28], a[27:17], a[16:12],
               e[38:28], e[27:17], e[16:12]);
    end
  endtask

  task automatic chk_int(input string nm, input int a, input int e);
    ncmp++;
    if (a != e) begin
      nbad++;
      $display("FAIL %s: got %0d want %0d", nm, a, e);
    end
  endtask

  task automatic step(input bit r, input bit e);
    exp_t x;
    @(negedge clk);
    rst = r;
    en  = e;
    if (r) begin
      mah = 0; mav = 0; mafs = 0;
      mbh = 0; mbv = 0; mbfs = 0;
    end else if (e) begin
      mafs = (mah == 1055 && mav == 627);
      if (mah == 1055) begin
        mah = 0;
        mav = (mav == 627) ? 0 : mav + 1;
      end else begin
        mah++;
      end
      mbfs = (mbh == 14 && mbv == 7);
      if (mbh == 14) begin
        mbh = 0;
        mbv = (mbv == 7) ? 0 : mbv + 1;
      end else begin
        mbh++;
      end
    end
    x = '{mah, mav, mafs, mbh, mbv, mbfs, phase};
    q.push_back(x);
  endtask

  // monitor: pops one expectation per clock and compares all three DUTs
  int cyc = 0;
  int prev_h = 0;
  bit prev_hb = 0;
  int hs_cnt = 0;
  int last_wrap = -1, last_wrap_ph = 0;
  int last_fs = -1;

  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        x = q.pop_front();
        cyc++;
        chk($sformatf("dut_a ph%0d", x.ph),
            act(ia.vcount, ia.hcount, ia.vsync, ia.vblnk,
                ia.hsync, ia.hblnk, fs_a, ia.rgb),
            pk(x.ah, x.av, x.afs, 800, 840, 968,
               600, 601, 605, 1'b1));
        chk($sformatf("dut_b ph%0d", x.ph),
            act(ib.vcount, ib.hcount, ib.vsync, ib.vblnk,
                ib.hsync, ib.hblnk, fs_b, ib.rgb),
            pk(x.bh, x.bv, x.bfs, 8, 10, 13, 4, 5, 7, 1'b1));
        chk($sformatf("dut_c ph%0d", x.ph),
            act(ic.vcount, ic.hcount, ic.vsync, ic.vblnk,
                ic.hsync, ic.hblnk, fs_c, ic.rgb),
            pk(x.bh, x.bv, x.bfs, 8, 10, 13, 4, 5, 7, 1'b0));

        if (x.ph != 2) hs_cnt = 0;
        else if (ia.hsync === 1'b1) hs_cnt++;

        if (ia.hblnk === 1'b1 && !prev_hb && x.ph != 5)
          chk_int("hblnk_rise", int'(ia.hcount), 800);
        if (ia.hblnk === 1'b0 && prev_hb && x.ph != 5)
          chk_int("hblnk_fall", int'(ia.hcount), 0);

        if (ia.hcount == 0 && prev_h == 1055) begin
          if (x.ph == 2) chk_int("hsync_width", hs_cnt, 128);
          hs_cnt = 0;
          if (last_wrap >= 0 && last_wrap_ph == x.ph
              && (x.ph == 2 || x.ph == 3))
            chk_int($sformatf("line_period ph%0d", x.ph),
                    cyc - last_wrap,
                    (x.ph == 3) ? 2112 : 1056);
          last_wrap = cyc;
          last_wrap_ph = x.ph;
        end

        if (fs_b === 1'b1 && x.ph == 2) begin
          if (last_fs >= 0)
            chk_int("frame_period_b", cyc - last_fs, 120);
          last_fs = cyc;
        end

        prev_h  = int'(ia.hcount);
        prev_hb = ia.hblnk;
      end
    end
  end

  initial begin
    bit found;

    phase = 1;
    repeat (3) step(1'b1, 1'b1);

    phase = 2;
    repeat (3300) step(1'b0, 1'b1);

    phase = 3;
    for (int i = 0; i < 4244; i++) step(1'b0, (i % 2) == 0);

    phase = 4;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1'b0, 1'b1);
      found = (mbh == 14 && mbv == 7);
    end
    chk_int("reach_b_last_pixel", int'(found), 1);
    repeat (5) step(1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1);

    phase = 5;
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(1'b0, 1'b1);
      found = (mbh == 5 && mbv == 3);
    end
    chk_int("reach_b_mid_frame", int'(found), 1);
    step(1'b1, 1'b1);
    repeat (20) step(1'b0, 1'b1);

    @(posedge clk);
    #3;
    chk_int("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end

endmodule
